// File: rtl/flush_controller_if.sv
// Flush-coordinate and VGA write bus between the flush controller and its neighbours.
// The master drives scan coordinates and VGA writes; the renderers answer on obj_*.
interface flush_controller_if;
  logic [6:0] flush_x;
  logic [6:0] flush_y;
  logic       obj_enable;
  logic [5:0] obj_colour;
  logic [6:0] vga_x;
  logic [6:0] vga_y;
  logic [5:0] vga_colour;
  logic       vga_plot;

  modport master (
    output flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot,
    input  obj_enable, obj_colour
  );

  modport slave (
    input  flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot,
    output obj_enable, obj_colour
  );
endinterface

// File: rtl/flush_controller.sv
// Frame-flush sequencer: raster-scans every pixel and issues one registered VGA write
// per pixel, taking the renderer colour where claimed and the background otherwise.
//
// state | meaning
// IDLE  | waiting for start, coordinates parked at (0,0)
// SCAN  | one pixel sampled and written per cycle
// DRAIN | last pixel write visible on the VGA port
// DONE  | one-cycle done pulse, frame counted; start here chains the next frame
module flush_controller #(
  parameter int         H_PIXELS  = 128,
  parameter int         V_PIXELS  = 120,
  parameter logic [5:0] BG_COLOUR = 6'b000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                frame_count,
  flush_controller_if.master        fb
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Compare against the last index so a full 128-wide row never needs an 8th bit.
  localparam logic [6:0] X_LAST = 7'(H_PIXELS - 1);
  localparam logic [6:0] Y_LAST = 7'(V_PIXELS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [6:0] flush_x_r;
  logic [6:0] flush_y_r;
  logic [6:0] vga_x_r;
  logic [6:0] vga_y_r;
  logic [5:0] vga_colour_r;
  logic       vga_plot_r;
  logic [7:0] frame_count_r;
  logic       clear_r;
  logic       start_ok;
  logic       row_end;
  logic       last_pixel;

  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign row_end    = (flush_x_r == X_LAST);
  assign last_pixel = (state == S_SCAN) && row_end && (flush_y_r == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_SCAN;
      S_SCAN:  if (last_pixel) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = start_ok ? S_SCAN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SCAN,
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_x_r     <= 7'd0;
      flush_y_r     <= 7'd0;
      vga_x_r       <= 7'd0;
      vga_y_r       <= 7'd0;
      vga_colour_r  <= BG_COLOUR;
      vga_plot_r    <= 1'b0;
      frame_count_r <= 8'd0;
      clear_r       <= 1'b0;
    end else begin
      if (start_ok) begin
        clear_r <= clear;
      end

      if (state == S_SCAN) begin
        vga_x_r      <= flush_x_r;
        vga_y_r      <= flush_y_r;
        vga_plot_r   <= 1'b1;
        vga_colour_r <= (fb.obj_enable && !clear_r) ? fb.obj_colour : BG_COLOUR;
        if (last_pixel) begin
          flush_x_r <= 7'd0;
          flush_y_r <= 7'd0;
        end else if (row_end) begin
          flush_x_r <= 7'd0;
          flush_y_r <= flush_y_r + 7'd1;
        end else begin
          flush_x_r <= flush_x_r + 7'd1;
        end
      end else begin
        vga_plot_r <= 1'b0;
      end

      // Counted on the way into DONE so the new value is visible alongside done.
      if (state == S_DRAIN) begin
        frame_count_r <= frame_count_r + 8'd1;
      end
    end
  end

  assign fb.flush_x    = flush_x_r;
  assign fb.flush_y    = flush_y_r;
  assign fb.vga_x      = vga_x_r;
  assign fb.vga_y      = vga_y_r;
  assign fb.vga_colour = vga_colour_r;
  assign fb.vga_plot   = vga_plot_r;
  assign frame_count   = frame_count_r;

endmodule

// File: tb/tb_flush_controller.sv
// Bench for flush_controller: a 4x3 instance for sequencing corner cases and a
// default 128x120 instance for full-size scan, both against a raster-order pixel model.
module tb_flush_controller;

  localparam int         HS   = 4;
  localparam int         VS   = 3;
  localparam int         NS   = HS * VS;
  localparam logic [5:0] BG_S = 6'b010101;
  localparam logic [5:0] BG_L = 6'b000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s = 1'b1, start_s = 1'b0, clear_s = 1'b0;
  logic       busy_s, done_s;
  logic [7:0] fc_s;
  logic       reset_l = 1'b1, start_l = 1'b0, clear_l = 1'b0;
  logic       busy_l, done_l;
  logic [7:0] fc_l;

  flush_controller_if fs();
  flush_controller_if fl();

  // Renderer stand-in: a claim/colour map indexed by the flush coordinate.
  logic       map_en  [0:127][0:127];
  logic [5:0] map_col [0:127][0:127];

  assign fs.obj_enable = map_en[fs.flush_y][fs.flush_x];
  assign fs.obj_colour = map_col[fs.flush_y][fs.flush_x];
  assign fl.obj_enable = map_en[fl.flush_y][fl.flush_x];
  assign fl.obj_colour = map_col[fl.flush_y][fl.flush_x];

  flush_controller #(.H_PIXELS(HS), .V_PIXELS(VS), .BG_COLOUR(BG_S)) dut_s (
    .clk(clk), .reset(reset_s), .start(start_s), .clear(clear_s),
    .busy(busy_s), .done(done_s), .frame_count(fc_s), .fb(fs)
  );

  flush_controller dut_l (
    .clk(clk), .reset(reset_l), .start(start_l), .clear(clear_l),
    .busy(busy_l), .done(done_l), .frame_count(fc_l), .fb(fl)
  );

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Small-instance write capture.
  typedef struct {
    int         x;
    int         y;
    logic [5:0] c;
  } wr_t;

  wr_t cap_s[$];
  int  runs_s[$];
  int  run_len = 0;
  int  lag_err = 0;
  int  pfx = 0, pfy = 0;

  always @(negedge clk) begin
    if (reset_s) begin
      run_len = 0;
      pfx = 0;
      pfy = 0;
    end else begin
      if (fs.vga_plot) begin
        cap_s.push_back('{x: int'(fs.vga_x), y: int'(fs.vga_y), c: fs.vga_colour});
        if (int'(fs.vga_x) != pfx || int'(fs.vga_y) != pfy) lag_err++;
        run_len++;
      end else if (run_len != 0) begin
        runs_s.push_back(run_len);
        run_len = 0;
      end
      pfx = int'(fs.flush_x);
      pfy = int'(fs.flush_y);
    end
  end

  // Large-instance checking inline: raster index predicts every coordinate and colour.
  int l_idx = 0, l_bad = 0, l_maxfx = 0, l_rises = 0, l_lastx = -1, l_lasty = -1;
  logic l_prev_plot = 1'b0;

  always @(negedge clk) begin
    if (!reset_l) begin
      if (int'(fl.flush_x) > l_maxfx) l_maxfx = int'(fl.flush_x);
      if (fl.vga_plot) begin
        int ex, ey;
        logic [5:0] ec;
        ex = l_idx % 128;
        ey = l_idx / 128;
        ec = (ey < 120 && map_en[ey][ex]) ? map_col[ey][ex] : BG_L;
        if (int'(fl.vga_x) != ex || int'(fl.vga_y) != ey || fl.vga_colour != ec) l_bad++;
        if (!l_prev_plot) l_rises++;
        l_lastx = int'(fl.vga_x);
        l_lasty = int'(fl.vga_y);
        l_idx++;
      end
      l_prev_plot = fl.vga_plot;
    end
  end

  task automatic fill_map(input int mode);
    for (int y = 0; y < 128; y++) begin
      for (int x = 0; x < 128; x++) begin
        map_col[y][x] = 6'($urandom);
        case (mode)
          1:       map_en[y][x] = (y == 1) && (x == 2 || x == 3);
          2:       map_en[y][x] = ($urandom_range(0, 2) == 0);
          default: map_en[y][x] = 1'b0;
        endcase
        if (mode == 1 && map_en[y][x]) map_col[y][x] = 6'b101100;
      end
    end
  endtask

  function automatic logic [5:0] model_colour(input int x, input int y, input bit clr);
    return (map_en[y][x] && !clr) ? map_col[y][x] : BG_S;
  endfunction

  task automatic check_writes(input string tag, input int nfr, input bit clr, input int exp_hits);
    int wbad = 0, hits = 0, mhits = 0, rbad = 0;
    check({tag, "_plots"}, cap_s.size(), nfr * NS);
    for (int i = 0; i < cap_s.size(); i++) begin
      int p, x, y;
      logic [5:0] ec;
      p  = i % NS;
      x  = p % HS;
      y  = p / HS;
      ec = model_colour(x, y, clr);
      if (cap_s[i].x != x || cap_s[i].y != y || cap_s[i].c != ec) wbad++;
      if (cap_s[i].c != BG_S) hits++;
      if (i < NS && ec != BG_S) mhits++;
    end
    check({tag, "_pixels"}, wbad, 0);
    if (exp_hits >= 0) check({tag, "_hits"}, hits, exp_hits);
    else               check({tag, "_hits"}, hits, mhits * nfr);
    check({tag, "_runs"}, runs_s.size(), nfr);
    foreach (runs_s[i]) if (runs_s[i] != NS) rbad++;
    check({tag, "_runlen"}, rbad, 0);
  endtask

  task automatic run_frame(input bit clr, input string tag, input int exp_hits);
    int n = 0;
    cap_s.delete();
    runs_s.delete();
    start_s = 1'b1;
    clear_s = clr;
    @(posedge clk); #1;
    start_s = 1'b0;
    clear_s = !clr;
    check({tag, "_first_xy"}, int'(fs.flush_x) + int'(fs.flush_y), 0);
    check({tag, "_busy"}, int'(busy_s), 1);
    while (!done_s && n < 200) begin
      @(posedge clk); #1;
      n++;
      start_s = (n == 4);
    end
    start_s = 1'b0;
    check({tag, "_done_lat"}, n, NS + 1);
    exp_fc++;
    @(posedge clk); #1;
    check({tag, "_done_once"}, int'(done_s), 0);
    check({tag, "_idle_busy"}, int'(busy_s), 0);
    check({tag, "_fc"}, int'(fc_s), exp_fc % 256);
    check_writes(tag, 1, clr, exp_hits);
  endtask

  task automatic back_to_back(input int nfr, input string tag);
    int cnt = 0, guard = 0, last = -1, ibad = 0;
    cap_s.delete();
    runs_s.delete();
    start_s = 1'b1;
    clear_s = 1'b0;
    while (cnt < nfr && guard < nfr * 20 + 50) begin
      @(posedge clk); #1;
      guard++;
      if (done_s) begin
        cnt++;
        if (last >= 0 && guard - last != NS + 2) ibad++;
        last = guard;
      end
    end
    start_s = 1'b0;
    check({tag, "_dones"}, cnt, nfr);
    check({tag, "_interval"}, ibad, 0);
    exp_fc += nfr;
    @(posedge clk); #1;
    check({tag, "_fc"}, int'(fc_s), exp_fc % 256);
    check({tag, "_idle"}, int'(busy_s), 0);
    check_writes(tag, nfr, 1'b0, -1);
  endtask

  typedef struct {
    string tag;
    bit    clr;
    int    mode;
    int    exp_hits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{tag: "bg_only",      clr: 1'b0, mode: 0, exp_hits: 0};
    vecs[1] = '{tag: "stripe",       clr: 1'b0, mode: 1, exp_hits: 2};
    vecs[2] = '{tag: "stripe_clear", clr: 1'b1, mode: 1, exp_hits: 0};
    vecs[3] = '{tag: "random",       clr: 1'b0, mode: 2, exp_hits: -1};
    vecs[4] = '{tag: "random_clear", clr: 1'b1, mode: 2, exp_hits: 0};

    fill_map(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot",   int'(fs.vga_plot), 0);
    check("rst_busy",   int'(busy_s), 0);
    check("rst_done",   int'(done_s), 0);
    check("rst_fc",     int'(fc_s), 0);
    check("rst_flush",  int'(fs.flush_x) + int'(fs.flush_y), 0);
    check("rst_vga_xy", int'(fs.vga_x) + int'(fs.vga_y), 0);
    check("rst_colour", int'(fs.vga_colour), int'(BG_S));
    reset_s = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      fill_map(vecs[i].mode);
      run_frame(vecs[i].clr, vecs[i].tag, vecs[i].exp_hits);
    end

    fill_map(0);
    back_to_back(3, "b2b");

    // Abandon a frame at pixel (1,1).
    cap_s.delete();
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    n = 0;
    while (!(fs.flush_x == 7'd1 && fs.flush_y == 7'd1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reach", int'(n < 50), 1);
    reset_s = 1'b1;
    @(posedge clk); #1;
    reset_s = 1'b0;
    check("mid_plot",  int'(fs.vga_plot), 0);
    check("mid_flush", int'(fs.flush_x) + int'(fs.flush_y), 0);
    check("mid_busy",  int'(busy_s), 0);
    check("mid_fc",    int'(fc_s), 0);
    exp_fc = 0;
    begin
      int dcount = 0, pcount = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done_s) dcount++;
        if (fs.vga_plot) pcount++;
      end
      check("mid_no_done", dcount, 0);
      check("mid_no_plot", pcount, 0);
    end
    run_frame(1'b0, "after_rst", 0);

    back_to_back(254, "wrap_pre");
    back_to_back(1, "wrap");
    check("lag", lag_err, 0);

    // Full-size frame on the default instance.
    fill_map(2);
    reset_l = 1'b0;
    @(posedge clk); #1;
    start_l = 1'b1;
    @(posedge clk); #1;
    start_l = 1'b0;
    n = 0;
    while (!done_l && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("big_done_lat", n, 128 * 120 + 1);
    check("big_plots",  l_idx, 15360);
    check("big_pixels", l_bad, 0);
    check("big_runs",   l_rises, 1);
    check("big_last_x", l_lastx, 127);
    check("big_last_y", l_lasty, 119);
    check("big_max_x",  l_maxfx, 127);
    @(posedge clk); #1;
    check("big_fc", int'(fc_l), 1);
    check("big_idle", int'(busy_l), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
